qix_vram_writer: RTL and testbench

- Video-CPU-side write/read port into the Qix video RAM.
- Completes the opposite side of the display scanout path: scanout only reads VRAM, and this block services CPU reads, direct writes and mask-merged (read-modify-write) writes.
- Supports direct CPU addressing and addressing through the latched-address register.
- Shares the VRAM CPU port with display fetches and always yields to them through disp_busy.

---
 rtl/qix_vram_writer.sv | 162 ++++++++++++++++
 tb/tb_qix_vram_writer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/qix_vram_writer.sv
// CPU-side access port into the Qix video RAM: reads, direct writes and mask-merged
// read-modify-write writes, always yielding the shared VRAM port to display fetches.
module qix_vram_writer #(
    parameter int          READ_LATENCY = 1,
    parameter logic [7:0]  MASK_RESET   = 8'hFF
) (
    input  logic        clk_20m,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic        cpu_latched,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ready,
    output logic        busy,
    input  logic        mask_we,
    input  logic        latch_hi_we,
    input  logic        latch_lo_we,
    output logic [15:0] latch_addr,
    input  logic        disp_busy,
    output logic [15:0] vram_addr,
    output logic        vram_re,
    output logic        vram_we,
    output logic [7:0]  vram_wdata,
    input  logic [7:0]  vram_rdata,
    output logic [2:0]  dbg_state
);

    // Handshake: cpu_req is a one-cycle strobe honoured only while idle (busy=0);
    // cpu_ready pulses for one cycle when the accepted access has finished.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        RWAIT = 3'd2,
        WR    = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [1:0] WAIT_LAST = 2'(READ_LATENCY - 1);

    state_t      state_q, state_d;
    logic [7:0]  mask_q, mask_d;
    logic [15:0] latch_q, latch_d;
    logic        op_we_q, op_we_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  cmask_q, cmask_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [1:0]  wait_q, wait_d;
    logic [15:0] vaddr_q, vaddr_d;
    logic [7:0]  vwdata_q, vwdata_d;
    logic        re_c, we_c, ready_c;

    always_ff @(posedge clk_20m or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            mask_q   <= MASK_RESET;
            latch_q  <= 16'h0000;
            op_we_q  <= 1'b0;
            addr_q   <= 16'h0000;
            cmask_q  <= 8'h00;
            data_q   <= 8'h00;
            rdata_q  <= 8'h00;
            wait_q   <= 2'd0;
            vaddr_q  <= 16'h0000;
            vwdata_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            latch_q  <= latch_d;
            op_we_q  <= op_we_d;
            addr_q   <= addr_d;
            cmask_q  <= cmask_d;
            data_q   <= data_d;
            rdata_q  <= rdata_d;
            wait_q   <= wait_d;
            vaddr_q  <= vaddr_d;
            vwdata_q <= vwdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        latch_d  = latch_q;
        op_we_d  = op_we_q;
        addr_d   = addr_q;
        cmask_d  = cmask_q;
        data_d   = data_q;
        rdata_d  = rdata_q;
        wait_d   = wait_q;
        vaddr_d  = vaddr_q;
        vwdata_d = vwdata_q;
        re_c     = 1'b0;
        we_c     = 1'b0;
        ready_c  = 1'b0;

        // Register loads land next cycle; an accept this cycle still sees the old values.
        if (mask_we)     mask_d        = cpu_wdata;
        if (latch_hi_we) latch_d[15:8] = cpu_wdata;
        if (latch_lo_we) latch_d[7:0]  = cpu_wdata;

        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    op_we_d = cpu_we;
                    addr_d  = cpu_latched ? latch_q : cpu_addr;
                    data_d  = cpu_wdata;
                    cmask_d = mask_q;
                    state_d = (cpu_we && (mask_q == 8'hFF)) ? WR : RD;
                end
            end
            RD: begin
                if (!disp_busy) begin
                    re_c    = 1'b1;
                    vaddr_d = addr_q;
                    wait_d  = 2'd0;
                    state_d = RWAIT;
                end
            end
            RWAIT: begin
                if (wait_q == WAIT_LAST) begin
                    if (op_we_q) begin
                        data_d  = (vram_rdata & ~cmask_q) | (data_q & cmask_q);
                        state_d = WR;
                    end else begin
                        rdata_d = vram_rdata;
                        state_d = DONE;
                    end
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            WR: begin
                if (!disp_busy) begin
                    we_c     = 1'b1;
                    vaddr_d  = addr_q;
                    vwdata_d = data_q;
                    state_d  = DONE;
                end
            end
            DONE: begin
                ready_c = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The bus address/data follow the strobe in its own cycle and then hold.
    assign vram_addr  = vaddr_d;
    assign vram_wdata = vwdata_d;
    assign vram_re    = re_c;
    assign vram_we    = we_c;
    assign cpu_ready  = ready_c;
    assign cpu_rdata  = rdata_q;
    assign busy       = (state_q != IDLE);
    assign latch_addr = latch_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_qix_vram_writer.sv
// Directed bench for qix_vram_writer with a behavioural VRAM (READ_LATENCY=1).
module tb_qix_vram_writer;

    logic        clk_20m = 1'b0;
    logic        reset_n;
    logic        cpu_req, cpu_we, cpu_latched;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ready, busy;
    logic        mask_we, latch_hi_we, latch_lo_we;
    logic [15:0] latch_addr;
    logic        disp_busy;
    logic [15:0] vram_addr;
    logic        vram_re, vram_we;
    logic [7:0]  vram_wdata, vram_rdata;
    logic [2:0]  dbg_state;

    int errors = 0;
    int checks = 0;

    always #5 clk_20m = ~clk_20m;

    qix_vram_writer #(.READ_LATENCY(1), .MASK_RESET(8'hFF)) dut (
        .clk_20m(clk_20m), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_latched(cpu_latched),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready), .busy(busy),
        .mask_we(mask_we), .latch_hi_we(latch_hi_we), .latch_lo_we(latch_lo_we),
        .latch_addr(latch_addr), .disp_busy(disp_busy),
        .vram_addr(vram_addr), .vram_re(vram_re), .vram_we(vram_we),
        .vram_wdata(vram_wdata), .vram_rdata(vram_rdata), .dbg_state(dbg_state)
    );

    // Behavioural VRAM: one-cycle read latency, bench-side preload port.
    logic [7:0]  mem [0:65535];
    logic [7:0]  rd_q = 8'h00;
    logic        pre_we = 1'b0;
    logic [15:0] pre_addr = 16'h0000;
    logic [7:0]  pre_data = 8'h00;

    always @(posedge clk_20m) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        if (vram_we) mem[vram_addr] <= vram_wdata;
        if (vram_re) rd_q <= mem[vram_addr];
    end
    assign vram_rdata = rd_q;

    int viol = 0;
    int we_total = 0;
    always @(negedge clk_20m) begin
        if (reset_n && disp_busy && (vram_re || vram_we)) viol++;
        if (vram_re && vram_we) viol++;
        if (vram_we) we_total++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_reg(input logic m, input logic h, input logic l, input logic [7:0] d);
        @(posedge clk_20m); #1;
        mask_we = m; latch_hi_we = h; latch_lo_we = l; cpu_wdata = d;
        @(posedge clk_20m); #1;
        mask_we = 1'b0; latch_hi_we = 1'b0; latch_lo_we = 1'b0;
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        @(posedge clk_20m); #1;
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk_20m); #1;
        pre_we = 1'b0;
    endtask

    // Per-operation observations, cycle 0 being the cpu_req cycle.
    int          r_re, r_we, r_rdy, n_we, n_rdy;
    logic [15:0] r_re_addr, r_we_addr;
    logic [7:0]  r_we_data, r_rdata;

    task automatic run_op(input logic we, input logic lat, input logic [15:0] addr,
                          input logic [7:0] wd, input int b_from, input int b_to,
                          input int req2, input logic lo_at0, input logic [7:0] lo_d);
        r_re = -1; r_we = -1; r_rdy = -1; n_we = 0; n_rdy = 0;
        r_re_addr = 16'h0; r_we_addr = 16'h0; r_we_data = 8'h0; r_rdata = 8'h0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk_20m); #1;
            cpu_req     = (c == 0) || (c == req2);
            cpu_we      = we;
            cpu_latched = (c == req2) ? 1'b0 : lat;
            cpu_addr    = (c == req2) ? ~addr : addr;
            cpu_wdata   = (c == req2) ? ~wd : ((lo_at0 && c == 0) ? lo_d : wd);
            latch_lo_we = lo_at0 && (c == 0);
            disp_busy   = (c >= b_from) && (c <= b_to);
            #3;
            if (vram_re && r_re < 0) begin r_re = c; r_re_addr = vram_addr; end
            if (vram_we) begin
                n_we++;
                if (r_we < 0) begin r_we = c; r_we_addr = vram_addr; r_we_data = vram_wdata; end
            end
            if (cpu_ready) begin
                n_rdy++;
                if (r_rdy < 0) begin r_rdy = c; r_rdata = cpu_rdata; end
            end
        end
        cpu_req = 1'b0; latch_lo_we = 1'b0; disp_busy = 1'b0;
    endtask

    int we_before;

    initial begin
        reset_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_latched = 1'b0;
        cpu_addr = 16'h0; cpu_wdata = 8'h0; mask_we = 1'b0; latch_hi_we = 1'b0;
        latch_lo_we = 1'b0; disp_busy = 1'b0;
        repeat (3) @(posedge clk_20m);
        #1 reset_n = 1'b1;
        #2;
        chk("rst_ready", cpu_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_vram_re", vram_re, 0);
        chk("rst_vram_we", vram_we, 0);
        chk("rst_vram_addr", vram_addr, 0);
        chk("rst_vram_wdata", vram_wdata, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_latch", latch_addr, 0);

        // Unmasked direct write: read skipped.
        run_op(1'b1, 1'b0, 16'h1234, 8'h5A, 99, -1, -1, 1'b0, 8'h00);
        chk("uw_re_cyc", r_re, -1);
        chk("uw_we_cyc", r_we, 1);
        chk("uw_we_addr", r_we_addr, 16'h1234);
        chk("uw_we_data", r_we_data, 8'h5A);
        chk("uw_rdy_cyc", r_rdy, 2);
        chk("uw_mem", mem[16'h1234], 8'h5A);
        chk("uw_addr_hold", vram_addr, 16'h1234);

        // Masked RMW write: (A5 & F0) | (3C & 0F) = AC.
        load_reg(1'b1, 1'b0, 1'b0, 8'h0F);
        preload(16'h0800, 8'hA5);
        run_op(1'b1, 1'b0, 16'h0800, 8'h3C, 99, -1, -1, 1'b0, 8'h00);
        chk("mw_re_cyc", r_re, 1);
        chk("mw_re_addr", r_re_addr, 16'h0800);
        chk("mw_we_cyc", r_we, 3);
        chk("mw_we_data", r_we_data, 8'hAC);
        chk("mw_rdy_cyc", r_rdy, 4);

        // Simultaneous latch loads both apply; then split loads.
        load_reg(1'b0, 1'b1, 1'b1, 8'h33);
        chk("latch_both", latch_addr, 16'h3333);
        load_reg(1'b0, 1'b1, 1'b0, 8'hF8);
        load_reg(1'b0, 1'b0, 1'b1, 8'h07);
        chk("latch_split", latch_addr, 16'hF807);

        // Latched read.
        preload(16'hF807, 8'h99);
        run_op(1'b0, 1'b1, 16'h0000, 8'h00, 99, -1, -1, 1'b0, 8'h00);
        chk("lr_re_cyc", r_re, 1);
        chk("lr_re_addr", r_re_addr, 16'hF807);
        chk("lr_rdy_cyc", r_rdy, 3);
        chk("lr_rdata", r_rdata, 8'h99);
        chk("lr_no_we", n_we, 0);

        // A write leaves cpu_rdata alone.
        run_op(1'b1, 1'b0, 16'h0040, 8'h12, 99, -1, -1, 1'b0, 8'h00);
        chk("wr_keeps_rdata", cpu_rdata, 8'h99);

        // Display stall during an unmasked write.
        load_reg(1'b1, 1'b0, 1'b0, 8'hFF);
        run_op(1'b1, 1'b0, 16'h4321, 8'hC3, 1, 4, -1, 1'b0, 8'h00);
        chk("st_we_cyc", r_we, 5);
        chk("st_rdy_cyc", r_rdy, 6);
        chk("st_we_data", r_we_data, 8'hC3);

        // Second cpu_req while busy is ignored.
        run_op(1'b1, 1'b0, 16'h2000, 8'h11, 1, 2, 2, 1'b0, 8'h00);
        chk("col_n_we", n_we, 1);
        chk("col_n_rdy", n_rdy, 1);
        chk("col_we_cyc", r_we, 3);
        chk("col_we_addr", r_we_addr, 16'h2000);
        chk("col_mem", mem[16'h2000], 8'h11);

        // latch_lo_we together with a latched request uses the old address.
        run_op(1'b0, 1'b1, 16'h0000, 8'h00, 99, -1, -1, 1'b1, 8'h55);
        chk("llo_re_addr", r_re_addr, 16'hF807);
        chk("llo_rdata", r_rdata, 8'h99);
        chk("llo_latch_new", latch_addr, 16'hF855);

        // RMW with stall in RD: (12 & 0F) | (AB & F0) = A2.
        load_reg(1'b1, 1'b0, 1'b0, 8'hF0);
        preload(16'h0010, 8'h12);
        run_op(1'b1, 1'b0, 16'h0010, 8'hAB, 1, 2, -1, 1'b0, 8'h00);
        chk("rs_re_cyc", r_re, 3);
        chk("rs_we_cyc", r_we, 5);
        chk("rs_we_data", r_we_data, 8'hA2);
        chk("rs_rdy_cyc", r_rdy, 6);

        // Reset in RWAIT of an RMW write: nothing written, everything back to reset.
        load_reg(1'b1, 1'b0, 1'b0, 8'h0F);
        we_before = we_total;
        @(posedge clk_20m); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_latched = 1'b0; cpu_addr = 16'h3000; cpu_wdata = 8'h77;
        @(posedge clk_20m); #1;
        cpu_req = 1'b0;
        @(posedge clk_20m); #1;
        reset_n = 1'b0;
        #2;
        chk("mr_busy", busy, 0);
        chk("mr_ready", cpu_ready, 0);
        chk("mr_vram_addr", vram_addr, 0);
        chk("mr_rdata", cpu_rdata, 0);
        chk("mr_latch", latch_addr, 0);
        repeat (2) @(posedge clk_20m);
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clk_20m);
        chk("mr_no_write", we_total, we_before);
        run_op(1'b1, 1'b0, 16'h3000, 8'h42, 99, -1, -1, 1'b0, 8'h00);
        chk("mr_mask_reset", r_re, -1);
        chk("mr_we_cyc", r_we, 1);
        chk("mr_rdy_cyc", r_rdy, 2);

        chk("no_strobe_violations", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
